// File: rtl/hls_driver_pkg.sv
// Shared types and constants for the HLS accelerator board driver:
// FSM states, status bit positions and the statistics counter width.
package hls_driver_pkg;

  localparam int CNT_W    = 16;
  localparam int STATUS_W = 6;

  localparam int STAT_PASS    = 0;
  localparam int STAT_FAIL    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_STRAY   = 3;
  localparam int STAT_BUSY    = 4;
  localparam int STAT_HALT    = 5;

  typedef enum logic [2:0] {
    S_RESET_GAP,
    S_START,
    S_BUSY,
    S_CHECK,
    S_GAP,
    S_HALT
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hls_mem_port.sv
// One memory channel: region decode, stray detection, registered read mux
// and the one-cycle acknowledge. Writes are only flagged here; the top arbitrates.
module hls_mem_port
  import hls_driver_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                WORD_W    = 32,
  parameter int                SIZE_W    = 6,
  parameter logic [ADDR_W-1:0] IN_BASE   = 32'h4000_0000,
  parameter int                IN_WORDS  = 16,
  parameter logic [ADDR_W-1:0] OUT_BASE  = 32'h4000_0100,
  parameter int                OUT_WORDS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          oe,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [SIZE_W-1:0]             size,
  input  logic [IN_WORDS*WORD_W-1:0]    image,
  input  logic [OUT_WORDS*WORD_W-1:0]   capture,
  output logic [WORD_W-1:0]             rdata,
  output logic                          rdy,
  output logic                          wr_hit,
  output logic [ADDR_W-1:0]             wr_idx,
  output logic                          stray
);

  localparam int BYTE_SH = $clog2(WORD_W / 8);

  logic [ADDR_W-1:0] in_idx, out_idx;
  logic              aligned, size_ok, in_hit, out_hit;
  logic [WORD_W-1:0] rdata_d, rdata_q;
  logic              rdy_d, rdy_q;

  assign in_idx  = (addr - IN_BASE) >> BYTE_SH;
  assign out_idx = (addr - OUT_BASE) >> BYTE_SH;
  assign aligned = (addr & ADDR_W'(WORD_W / 8 - 1)) == '0;
  assign size_ok = size == SIZE_W'(WORD_W);
  assign in_hit  = (addr >= IN_BASE) && (in_idx < ADDR_W'(IN_WORDS)) && aligned && size_ok;
  assign out_hit = (addr >= OUT_BASE) && (out_idx < ADDR_W'(OUT_WORDS)) && aligned && size_ok;

  // oe together with we is handled as a write but still flagged as stray.
  assign wr_hit = we && out_hit;
  assign wr_idx = out_idx;
  assign stray  = (we && (oe || !out_hit)) || (oe && !we && !in_hit && !out_hit);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rdata_d = '0;
    rdy_d   = oe || we;
    if (oe && !we) begin
      for (int w = 0; w < IN_WORDS; w++)
        if (in_hit && in_idx == ADDR_W'(w)) rdata_d = image[w*WORD_W +: WORD_W];
      for (int w = 0; w < OUT_WORDS; w++)
        if (out_hit && out_idx == ADDR_W'(w)) rdata_d = capture[w*WORD_W +: WORD_W];
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdata = rdata_q;
  assign rdy   = rdy_q;

endmodule

// File: rtl/hls_mem_driver.sv
// Board-level driver for an HLS core: pulses start, serves the input image,
// captures result writes, checks them against a digest and keeps statistics.
module hls_mem_driver
  import hls_driver_pkg::*;
#(
  parameter int                CHANNELS   = 2,
  parameter int                ADDR_W     = 32,
  parameter int                WORD_W     = 32,
  parameter int                SIZE_W     = 6,
  parameter logic [ADDR_W-1:0] IN_BASE    = 32'h4000_0000,
  parameter int                IN_WORDS   = 16,
  parameter logic [ADDR_W-1:0] OUT_BASE   = 32'h4000_0100,
  parameter int                OUT_WORDS  = 2,
  parameter int                GAP_CYCLES = 200,
  parameter int                TIMEOUT    = 65535,
  parameter int                RUNS       = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IN_WORDS*WORD_W-1:0]    image,
  input  logic [OUT_WORDS*WORD_W-1:0]   expected,
  output logic                          start_port,
  input  logic                          done_port,
  input  logic [CHANNELS-1:0]           Mout_oe_ram,
  input  logic [CHANNELS-1:0]           Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]    Mout_addr_ram,
  input  logic [CHANNELS*WORD_W-1:0]    Mout_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]    Mout_data_ram_size,
  output logic [CHANNELS*WORD_W-1:0]    M_Rdata_ram,
  output logic [CHANNELS-1:0]           M_DataRdy,
  output logic [CNT_W-1:0]              pass_count,
  output logic [CNT_W-1:0]              fail_count,
  output logic [STATUS_W-1:0]           status,
  output logic [OUT_WORDS*WORD_W-1:0]   capture
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int RUN_W = $clog2(RUNS + 2);

  state_e                      state_d, state_q;
  logic [GAP_W-1:0]            gap_d, gap_q;
  logic [TMR_W-1:0]            tmr_d, tmr_q;
  logic                        tout_d, tout_q;
  logic [RUN_W-1:0]            run_d, run_q;
  logic [CNT_W-1:0]            pass_d, pass_q, fail_d, fail_q;
  logic [3:0]                  stat_d, stat_q;
  logic [OUT_WORDS*WORD_W-1:0] capture_d, capture_q;

  logic [CHANNELS-1:0]         wr_hit, stray;
  logic [ADDR_W-1:0]           wr_idx [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_port
    hls_mem_port #(
      .ADDR_W(ADDR_W), .WORD_W(WORD_W), .SIZE_W(SIZE_W),
      .IN_BASE(IN_BASE), .IN_WORDS(IN_WORDS),
      .OUT_BASE(OUT_BASE), .OUT_WORDS(OUT_WORDS)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .oe      (Mout_oe_ram[c]),
      .we      (Mout_we_ram[c]),
      .addr    (Mout_addr_ram[c*ADDR_W +: ADDR_W]),
      .size    (Mout_data_ram_size[c*SIZE_W +: SIZE_W]),
      .image   (image),
      .capture (capture_q),
      .rdata   (M_Rdata_ram[c*WORD_W +: WORD_W]),
      .rdy     (M_DataRdy[c]),
      .wr_hit  (wr_hit[c]),
      .wr_idx  (wr_idx[c]),
      .stray   (stray[c])
    );
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    tmr_d     = tmr_q;
    tout_d    = tout_q;
    run_d     = run_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    stat_d    = stat_q;
    capture_d = capture_q;

    // Ascending channel order lets the highest channel win a same-word collision.
    for (int c = 0; c < CHANNELS; c++)
      for (int w = 0; w < OUT_WORDS; w++)
        if (wr_hit[c] && wr_idx[c] == ADDR_W'(w))
          capture_d[w*WORD_W +: WORD_W] = Mout_Wdata_ram[c*WORD_W +: WORD_W];
    if (|stray) stat_d[STAT_STRAY] = 1'b1;

    case (state_q)
      S_RESET_GAP, S_GAP: begin
        if (gap_q == '0) state_d = S_START;
        else             gap_d   = gap_q - 1'b1;
      end
      S_START: begin
        capture_d = '0;
        tmr_d     = '0;
        tout_d    = 1'b0;
        state_d   = S_BUSY;
      end
      S_BUSY: begin
        if (done_port) begin
          state_d = S_CHECK;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_d              = S_CHECK;
          tout_d               = 1'b1;
          stat_d[STAT_TIMEOUT] = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (capture_q == expected && !tout_q) begin
          pass_d            = sat_inc(pass_q);
          stat_d[STAT_PASS] = 1'b1;
        end else begin
          fail_d            = sat_inc(fail_q);
          stat_d[STAT_PASS] = 1'b0;
          stat_d[STAT_FAIL] = 1'b1;
        end
        gap_d   = GAP_W'(GAP_CYCLES);
        state_d = S_GAP;
        if (RUNS != 0) begin
          run_d = run_q + 1'b1;
          if (int'(run_q) + 1 >= RUNS) state_d = S_HALT;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET_GAP;
    endcase
  end

  // NOTE: capture is a small register file, not a RAM, so it is reset with the rest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RESET_GAP;
      gap_q     <= GAP_W'(GAP_CYCLES);
      tmr_q     <= '0;
      tout_q    <= 1'b0;
      run_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      stat_q    <= '0;
      capture_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      tmr_q     <= tmr_d;
      tout_q    <= tout_d;
      run_q     <= run_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      stat_q    <= stat_d;
      capture_q <= capture_d;
    end
  end

  always_comb begin
    status            = {2'b00, stat_q};
    status[STAT_BUSY] = state_q == S_BUSY;
    status[STAT_HALT] = state_q == S_HALT;
  end

  assign start_port = state_q == S_START;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign capture    = capture_q;

endmodule

// File: tb/tb_hls_mem_driver.sv
// Self-checking bench for hls_mem_driver: run sequencing, timeout, halt,
// stray accesses, write arbitration and asynchronous reset.
module tb_hls_mem_driver;

  localparam int G  = 200;
  localparam int TO = 100;
  localparam logic [31:0] IN_B  = 32'h4000_0000;
  localparam logic [31:0] OUT_B = 32'h4000_0100;
  localparam logic [31:0] W0 = 32'hd98c1dd4;
  localparam logic [31:0] W1 = 32'h04b2008f;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] image;
  logic [63:0]  expected;
  logic         start_port, done_port;
  logic [1:0]   oe, we;
  logic [63:0]  addr, wdata;
  logic [11:0]  size;
  logic [63:0]  rdata;
  logic [1:0]   rdy;
  logic [15:0]  pass_count, fail_count;
  logic [5:0]   status;
  logic [63:0]  capture;

  hls_mem_driver #(.TIMEOUT(TO), .RUNS(3), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .image(image), .expected(expected),
    .start_port(start_port), .done_port(done_port),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .M_Rdata_ram(rdata), .M_DataRdy(rdy),
    .pass_count(pass_count), .fail_count(fail_count),
    .status(status), .capture(capture)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          ch;
    bit          o;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [5:0]  sz;
    logic [31:0] exp_rd;
  } vec_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   start_cnt = 0, start_cyc = 0, check_cyc = 0, rel_cyc = 0;
  bit   busy_prev = 1'b0, check_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each acknowledge pops the oldest outstanding request of its channel.
  always @(negedge clk) begin
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      if (rdy[c]) begin
        if ((c == 0 && sb0.size() == 0) || (c == 1 && sb1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL ack_unexpected: channel %0d acknowledged with no request", c);
        end else begin
          e = (c == 0) ? sb0.pop_front() : sb1.pop_front();
          if (e.is_rd) check($sformatf("rdata_ch%0d", c), rdata[c*32 +: 32], e.data);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    if (start_port) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (busy_prev && !status[4]) begin
      check_seen = 1'b1;
      check_cyc  = cyc;
    end
    busy_prev = status[4];
  endtask

  task automatic clear_bus();
    oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
  endtask

  task automatic drive(input int ch, input bit o, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [5:0] sz, input logic [31:0] exp_rd);
    exp_t e;
    oe[ch] = o;
    we[ch] = w;
    addr[ch*32 +: 32]  = a;
    wdata[ch*32 +: 32] = d;
    size[ch*6 +: 6]    = sz;
    e.is_rd = o && !w;
    e.data  = exp_rd;
    if (ch == 0) sb0.push_back(e);
    else         sb1.push_back(e);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 1000; i++) begin
      step();
      if (start_port) break;
    end
    check("start_seen", start_port, 1'b1);
    check_seen = 1'b0;
  endtask

  task automatic wait_check();
    for (int i = 0; i < 300 && !check_seen; i++) step();
    check("check_seen", check_seen, 1'b1);
  endtask

  // From the START cycle: read word0, write the digest together with done.
  task automatic run_pass(input logic [5:0] busy_status);
    step();
    check("busy_status", status, busy_status);
    drive(0, 1, 0, IN_B, 0, 6'd32, 32'h80);
    step();
    clear_bus();
    drive(0, 0, 1, OUT_B, W0, 6'd32, 0);
    drive(1, 0, 1, OUT_B + 4, W1, 6'd32, 0);
    done_port = 1'b1;
    step();
    clear_bus();
    done_port = 1'b0;
    wait_check();
    check("capture_at_check", capture, expected);
  endtask

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0, 1'b1, 1'b0, IN_B,            32'h0,        6'd32, 32'h80};
    vt[1] = '{1, 1'b1, 1'b0, IN_B + 32'h3c,   32'h0,        6'd32, 32'hcafef00d};
    vt[2] = '{0, 1'b1, 1'b0, IN_B + 32'h40,   32'h0,        6'd32, 32'h0};
    vt[3] = '{1, 1'b0, 1'b1, OUT_B + 4,       32'h12345678, 6'd32, 32'h0};
    vt[4] = '{0, 1'b1, 1'b0, OUT_B + 4,       32'h0,        6'd32, 32'h12345678};
    vt[5] = '{1, 1'b1, 1'b0, IN_B,            32'h0,        6'd16, 32'h0};
    vt[6] = '{0, 1'b1, 1'b0, IN_B - 4,        32'h0,        6'd32, 32'h0};
    vt[7] = '{1, 1'b1, 1'b0, OUT_B + 8,       32'h0,        6'd32, 32'h0};

    reset = 1'b0;
    done_port = 1'b0;
    clear_bus();
    image = '0;
    image[31:0] = 32'h80;
    expected = {W1, W0};
    repeat (3) step();
    check("rst_start", start_port, 1'b0);
    check("rst_rdy", rdy, 2'b00);
    check("rst_rdata", rdata, 64'h0);
    check("rst_capture", capture, 64'h0);
    check("rst_counts", {pass_count, fail_count}, 32'h0);
    check("rst_status", status, 6'b000000);

    reset = 1'b1;
    rel_cyc = cyc;
    start_cnt = 0;
    wait_start();
    check("first_start_delay", start_cyc - rel_cyc, G + 1);

    // Run 1: digest written in the same cycle as done.
    run_pass(6'b010000);
    step();
    check("run1_pass", pass_count, 16'd1);
    check("run1_fail", fail_count, 16'd0);
    repeat (5) step();
    done_port = 1'b1;
    step();
    done_port = 1'b0;

    // Run 2: word1 wrong.
    wait_start();
    check("run2_start_gap", start_cyc - check_cyc, G + 2);
    step();
    check("status_after_pass", status, 6'b010001);
    drive(0, 0, 1, OUT_B, W0, 6'd32, 0);
    drive(1, 0, 1, OUT_B + 4, 32'h0, 6'd32, 0);
    step();
    clear_bus();
    step();
    done_port = 1'b1;
    step();
    done_port = 1'b0;
    wait_check();
    step();
    check("run2_fail", fail_count, 16'd1);
    check("run2_pass", pass_count, 16'd1);
    check("run2_status", status, 6'b000010);

    // Run 3: no done, timeout, then halt.
    wait_start();
    check("run3_start_gap", start_cyc - check_cyc, G + 2);
    wait_check();
    check("timeout_latency", check_cyc - start_cyc, TO + 1);
    step();
    check("run3_fail", fail_count, 16'd2);
    check("halt_status", status, 6'b100110);
    repeat (250) step();
    check("start_pulses", start_cnt, 3);
    check("still_halted", status[5], 1'b1);

    // Stray accesses: misaligned read and unmapped write.
    image[511:480] = 32'hcafef00d;
    drive(0, 1, 0, IN_B + 2, 0, 6'd32, 32'h0);
    drive(1, 0, 1, 32'h5000_0000, 32'hdeadbeef, 6'd32, 0);
    step();
    clear_bus();
    check("stray_ack", rdy, 2'b11);
    check("stray_rdata", rdata[31:0], 32'h0);
    check("stray_flag", status[3], 1'b1);
    check("stray_capture", capture, 64'h0);
    step();
    check("ack_pulse", rdy, 2'b00);

    for (int i = 0; i < 8; i++) begin
      clear_bus();
      drive(vt[i].ch, vt[i].o, vt[i].w, vt[i].a, vt[i].d, vt[i].sz, vt[i].exp_rd);
      step();
    end
    clear_bus();
    step();
    step();
    check("table_capture", capture, {32'h12345678, 32'h0});

    drive(0, 0, 1, OUT_B, 32'haaaa0001, 6'd32, 0);
    drive(1, 0, 1, OUT_B, 32'hbbbb0002, 6'd32, 0);
    step();
    clear_bus();
    check("collision_high_wins", capture[31:0], 32'hbbbb0002);
    drive(0, 1, 1, OUT_B + 4, 32'h55, 6'd32, 0);
    step();
    clear_bus();
    check("oe_we_is_write", capture[63:32], 32'h55);

    // Asynchronous reset while halted with non-zero counters.
    #2 reset = 1'b0;
    #1;
    check("async_rst_counts", {pass_count, fail_count}, 32'h0);
    check("async_rst_status", status, 6'b000000);
    check("async_rst_capture", capture, 64'h0);
    step();
    reset = 1'b1;
    rel_cyc = cyc;
    wait_start();
    check("restart_delay", start_cyc - rel_cyc, G + 1);
    run_pass(6'b010000);
    step();
    check("post_rst_pass", pass_count, 16'd1);

    // Reset in the middle of BUSY.
    wait_start();
    step();
    drive(0, 0, 1, OUT_B, W0, 6'd32, 0);
    step();
    clear_bus();
    check("mid_busy", status[4], 1'b1);
    check("mid_busy_capture", capture[31:0], W0);
    #2 reset = 1'b0;
    #1;
    check("midrun_rst_pass", pass_count, 16'd0);
    check("midrun_rst_status", status, 6'b000000);
    check("midrun_rst_capture", capture, 64'h0);
    check("midrun_rst_start", start_port, 1'b0);
    step();
    reset = 1'b1;
    rel_cyc = cyc;
    wait_start();
    check("midrun_restart_delay", start_cyc - rel_cyc, G + 1);
    step();
    step();
    check("sb_drain_ch0", sb0.size(), 0);
    check("sb_drain_ch1", sb1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
